// File: rtl/sap_out_display.sv
// Board-side display for the SAP output register: a serial double-dabble engine turns each new
// 8-bit value into three BCD digits, which drive a multiplexed 3-digit seven-segment display.
module sap_out_display #(
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic        clk,
  input  logic        reg_clr,
  input  logic        en,
  input  logic [7:0]  out_data,
  output logic [11:0] bcd,
  output logic        valid,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int            CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [1:0]    state;
  logic [7:0]    last_val;
  logic [19:0]   shreg;     // {hundreds, tens, ones, binary}
  logic [2:0]    bit_cnt;
  logic          start;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [1:0]    idx_next;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg_next;

  // One double-dabble step: correct every BCD nibble >= 5, then shift the whole register left.
  function automatic logic [19:0] dabble(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    for (int k = 0; k < 3; k++) begin
      if (t[8+4*k +: 4] >= 4'd5) t[8+4*k +: 4] = t[8+4*k +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  assign start = (state == ST_IDLE) && en && (out_data != last_val);
  assign busy  = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reg_clr) begin
    if (reg_clr) begin
      state    <= ST_IDLE;
      last_val <= 8'h00;
      shreg    <= 20'h0_0000;
      bit_cnt  <= 3'd0;
      bcd      <= 12'h000;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg    <= {12'h000, out_data};
            last_val <= out_data;
            bit_cnt  <= 3'd0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg   <= dabble(shreg);
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= ST_DONE;
        end
        ST_DONE: begin
          bcd   <= shreg[19:8];
          valid <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // an and seg are registered from the next index so they switch on the same edge as idx.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    idx_next = idx;
    if (en && cnt == CNT_MAX) idx_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;

    nib   = bcd[3:0];
    blank = 1'b0;
    case (idx_next)
      2'd1: begin
        nib   = bcd[7:4];
        blank = BLANK_LZ && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
      end
      2'd2: begin
        nib   = bcd[11:8];
        blank = BLANK_LZ && (bcd[11:8] == 4'd0);
      end
      default: ;
    endcase

    if (blank)               seg_next = SEG_OFF;
    else if (SEG_ACTIVE_LOW) seg_next = ~seg_decode(nib);
    else                     seg_next = seg_decode(nib);
  end

  always_ff @(posedge clk or posedge reg_clr) begin
    if (reg_clr) begin
      cnt <= '0;
      idx <= 2'd0;
      an  <= 3'b111;
      seg <= SEG_OFF;
    end else if (en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      idx <= idx_next;
      an  <= ~(3'b001 << idx_next);
      seg <= seg_next;
    end else begin
      an  <= 3'b111;
      seg <= SEG_OFF;
    end
  end

endmodule

// File: tb/tb_sap_out_display.sv
// Directed bench for sap_out_display: two instances (blanking on / off) share the stimulus.
module tb_sap_out_display;

  logic        clk = 1'b0;
  logic        reg_clr;
  logic        en;
  logic [7:0]  out_data;
  logic [11:0] bcd, bcd_nb;
  logic        valid, valid_nb, busy, busy_nb;
  logic [6:0]  seg, seg_nb;
  logic [2:0]  an, an_nb;

  int n_cmp = 0;
  int n_bad = 0;
  int n_vld = 0;
  bit seen99 = 1'b0;

  sap_out_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reg_clr(reg_clr), .en(en), .out_data(out_data),
    .bcd(bcd), .valid(valid), .busy(busy), .seg(seg), .an(an)
  );

  sap_out_display #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .reg_clr(reg_clr), .en(en), .out_data(out_data),
    .bcd(bcd_nb), .valid(valid_nb), .busy(busy_nb), .seg(seg_nb), .an(an_nb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) n_vld++;
    if (valid && bcd == 12'h099) seen99 = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after the detect edge E0; counts edges until valid and busy cycles on the way.
  task automatic finish_conv(input logic [11:0] exp, input int exp_lat, input string tag);
    int k;
    int nb;
    k  = 0;
    nb = 1;
    while (!valid && k < 40) begin
      step();
      k++;
      if (busy) nb++;
    end
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_busy_cycles"}, nb, exp_lat);
    check({tag, "_bcd"}, bcd, exp);
    step();
  endtask

  task automatic convert(input logic [7:0] v, input logic [11:0] exp, input string tag);
    out_data = v;
    step();
    check({tag, "_busy_e0"}, busy, 1'b1);
    finish_conv(exp, 9, tag);
  endtask

  task automatic show(input int d, input logic [6:0] exp, input logic [6:0] exp_nb, input string tag);
    logic [2:0] want;
    int k;
    want = ~(3'b001 << d);
    k = 0;
    while (an != want && k < 20) begin
      step();
      k++;
    end
    check({tag, "_an"}, an, want);
    check({tag, "_seg"}, seg, exp);
    check({tag, "_seg_nb"}, seg_nb, exp_nb);
  endtask

  initial begin
    int k;
    int base;
    logic [2:0] prev_an;
    logic [2:0] saved_an;

    reg_clr  = 1'b1;
    en       = 1'b1;
    out_data = 8'd0;
    #12;
    check("rst_bcd", bcd, 12'h000);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_an", an, 3'b111);
    check("rst_seg", seg, 7'h7F);

    // Reset then idle: an walks 110 -> 101 -> 011 every 4 clocks, only the ones digit lit.
    @(posedge clk);
    #1;
    reg_clr = 1'b0;
    step();
    check("idle_an0", an, 3'b110);
    check("idle_seg0", seg, 7'h40);
    repeat (3) step();
    check("idle_an1", an, 3'b101);
    check("idle_seg1", seg, 7'h7F);
    check("idle_seg1_nb", seg_nb, 7'h40);
    repeat (4) step();
    check("idle_an2", an, 3'b011);
    check("idle_seg2", seg, 7'h7F);
    check("idle_no_valid", n_vld, 0);

    convert(8'hFF, 12'h255, "c255");
    show(0, 7'b0010010, 7'b0010010, "c255_d0");
    show(1, 7'b0010010, 7'b0010010, "c255_d1");
    show(2, 7'b0100100, 7'b0100100, "c255_d2");

    convert(8'd7, 12'h007, "c7");
    show(0, 7'h78, 7'h78, "c7_d0");
    show(1, 7'h7F, 7'h40, "c7_d1");
    show(2, 7'h7F, 7'h40, "c7_d2");

    convert(8'd100, 12'h100, "c100");
    show(0, 7'h40, 7'h40, "c100_d0");
    show(1, 7'h40, 7'h40, "c100_d1");
    show(2, 7'h79, 7'h79, "c100_d2");

    // Change while busy: 99 is overwritten before the engine is free again.
    base = n_vld;
    out_data = 8'd42;
    step();
    out_data = 8'd99;
    step();
    out_data = 8'd200;
    finish_conv(12'h042, 8, "busy42");
    check("busy200_busy_e0", busy, 1'b1);
    finish_conv(12'h200, 9, "busy200");
    repeat (15) step();
    check("busy_valid_count", n_vld, base + 2);
    check("busy_no99", seen99, 1'b0);

    // Reset in the middle of a 200 conversion.
    convert(8'd5, 12'h005, "c5");
    out_data = 8'd200;
    step();
    repeat (4) step();
    check("mid_busy_before", busy, 1'b1);
    base = n_vld;
    reg_clr = 1'b1;
    #1;
    check("mid_busy", busy, 1'b0);
    check("mid_bcd", bcd, 12'h000);
    check("mid_an", an, 3'b111);
    check("mid_seg", seg, 7'h7F);
    step();
    step();
    reg_clr = 1'b0;
    check("mid_no_valid", n_vld, base);
    convert(8'd200, 12'h200, "mid_reconv");

    // Enable gating: align to a digit change so the refresh counter is at 0.
    prev_an = an;
    k = 0;
    while (an == prev_an && k < 20) begin
      step();
      k++;
    end
    check("gate_align", k < 20, 1'b1);
    saved_an = an;
    base = n_vld;
    en = 1'b0;
    out_data = 8'd77;
    repeat (20) step();
    check("gate_an", an, 3'b111);
    check("gate_busy", busy, 1'b0);
    check("gate_no_valid", n_vld, base);
    en = 1'b1;
    step();
    check("gate_an_frozen", an, saved_an);
    check("gate_busy_e0", busy, 1'b1);
    finish_conv(12'h077, 9, "gate77");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
